hms_seg7_scanner: RTL and testbench

- Downstream display stage for the stopwatch: consumes hour_out/min_out/sec_out from stopwatch_top and drives an 8-digit multiplexed, common-anode 7-segment display (active-low anodes and segments) as HH.MM.SS on the low six digits.
- Snapshots the time once per scan frame so that a displayed frame never mixes old and new values.
- Scans the digits with a prescaled refresh tick and registers all outputs.

---
 rtl/hms_seg7_pkg.sv | 38 +++
 rtl/hms_seg7_scanner_decoder.sv | 32 +++
 rtl/hms_seg7_scanner.sv | 156 +++++++++++++++
 tb/tb_hms_seg7_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hms_seg7_pkg.sv
// Shared constants for the HH.MM.SS seven-segment scanner: segment codes,
// scan digit indices and BCD split helpers.
package hms_seg7_pkg;

  localparam int NUM_SCAN_DIGITS = 6;

  localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
  localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
  localparam logic [2:0] IDX_HOUR_TENS = 3'd5;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [7:0] AN_OFF = 8'hFF;

  function automatic logic [3:0] tens_of(input logic [5:0] value);
    return 4'(value / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] value);
    return 4'(value % 6'd10);
  endfunction

endpackage

// File: rtl/hms_seg7_scanner_decoder.sv
// Combinational BCD to active-low seven-segment decoder with a dash override.
module seg7_decoder
  import hms_seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  output logic [6:0] seg
);

  // Map one BCD digit (or the dash request) to its segment pattern
  always_comb begin
    seg = SEG_DASH;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/hms_seg7_scanner.sv
// Multiplexed HH.MM.SS driver for an 8-digit common-anode display with per-frame snapshot.
// Optional blink support is enabled with `define HMS_SEG7_BLINK_EN.
module hms_seg7_scanner
  import hms_seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
`ifdef HMS_SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 83
`endif
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
`ifdef HMS_SEG7_BLINK_EN
  input  logic       blink_in,
`endif
  output logic [7:0] an_out,
  output logic [6:0] seg_out,
  output logic       dp_out
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST      = 3'(NUM_SCAN_DIGITS - 1);

  logic [PW-1:0] prescaler_r;
  logic [2:0]    digit_idx_r;
  logic [4:0]    hour_snap_r;
  logic [5:0]    min_snap_r;
  logic [5:0]    sec_snap_r;
  logic          tick_s;
  logic          frame_wrap_s;
  logic [3:0]    digit_s;
  logic          dash_s;
  logic          dp_s;
  logic [7:0]    an_s;
  logic [6:0]    seg_s;
  logic          blank_s;

  assign tick_s       = (prescaler_r == PRESCALE_LAST);
  assign frame_wrap_s = tick_s && (digit_idx_r == IDX_LAST);

  // Refresh prescaler, scan position and the frame-boundary time snapshot
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      prescaler_r <= PW'(0);
      digit_idx_r <= 3'd0;
      hour_snap_r <= 5'd0;
      min_snap_r  <= 6'd0;
      sec_snap_r  <= 6'd0;
    end else begin
      prescaler_r <= tick_s ? PW'(0) : prescaler_r + PW'(1);
      if (frame_wrap_s) begin
        digit_idx_r <= 3'd0;
        hour_snap_r <= hour_in;
        min_snap_r  <= min_in;
        sec_snap_r  <= sec_in;
      end else if (tick_s) begin
        digit_idx_r <= digit_idx_r + 3'd1;
      end
    end
  end

  // Select the digit, range-check its field and place the separators
  always_comb begin
    digit_s = 4'd0;
    dash_s  = 1'b1;
    dp_s    = 1'b1;
    case (digit_idx_r)
      IDX_SEC_ONES: begin
        digit_s = ones_of(sec_snap_r);
        dash_s  = (sec_snap_r > 6'd59);
      end
      IDX_SEC_TENS: begin
        digit_s = tens_of(sec_snap_r);
        dash_s  = (sec_snap_r > 6'd59);
      end
      IDX_MIN_ONES: begin
        digit_s = ones_of(min_snap_r);
        dash_s  = (min_snap_r > 6'd59);
        dp_s    = 1'b0;
      end
      IDX_MIN_TENS: begin
        digit_s = tens_of(min_snap_r);
        dash_s  = (min_snap_r > 6'd59);
      end
      IDX_HOUR_ONES: begin
        digit_s = ones_of({1'b0, hour_snap_r});
        dash_s  = (hour_snap_r > 5'd23);
        dp_s    = 1'b0;
      end
      IDX_HOUR_TENS: begin
        digit_s = tens_of({1'b0, hour_snap_r});
        dash_s  = (hour_snap_r > 5'd23);
      end
      default: begin
        digit_s = 4'd0;
        dash_s  = 1'b1;
        dp_s    = 1'b1;
      end
    endcase
  end

  // Digit index never exceeds 5, so an_out[7:6] stay high
  assign an_s = ~(8'd1 << digit_idx_r);

  seg7_decoder u_decoder (
    .bcd  (digit_s),
    .dash (dash_s),
    .seg  (seg_s)
  );

`ifdef HMS_SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_r;
  logic          phase_r;

  // Frame counter and blink phase; a dropped request clears the phase at the next frame
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= FW'(0);
      phase_r     <= 1'b0;
    end else if (frame_wrap_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_r <= FW'(0);
        phase_r     <= blink_in & ~phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + FW'(1);
        phase_r     <= blink_in & phase_r;
      end
    end
  end

  assign blank_s = blink_in & phase_r;
`else
  assign blank_s = 1'b0;
`endif

  // Registered display drive
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= blank_s ? AN_OFF : an_s;
      seg_out <= seg_s;
      dp_out  <= blank_s | dp_s;
    end
  end

endmodule

// File: tb/tb_hms_seg7_scanner.sv
// Self-checking bench for hms_seg7_scanner: a time-arithmetic display model checked
// every cycle, plus hand-computed display values at chosen points of the scan.
module tb_hms_seg7_scanner;

  localparam int D  = 4;
  localparam int FR = 6 * D;
  localparam int BF = 2;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b0;
  logic [4:0] hour_in    = 5'd0;
  logic [5:0] min_in     = 6'd0;
  logic [5:0] sec_in     = 6'd0;
  logic [7:0] an_out;
  logic [6:0] seg_out;
  logic       dp_out;
`ifdef HMS_SEG7_BLINK_EN
  logic       blink_in   = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

`ifdef HMS_SEG7_BLINK_EN
  hms_seg7_scanner #(.REFRESH_DIV(D), .BLINK_FRAMES(BF)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .hour_in    (hour_in),
    .min_in     (min_in),
    .sec_in     (sec_in),
    .blink_in   (blink_in),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out)
  );
`else
  hms_seg7_scanner #(.REFRESH_DIV(D)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .hour_in    (hour_in),
    .min_in     (min_in),
    .sec_in     (sec_in),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out)
  );
`endif

  always #5 clk_100MHz = ~clk_100MHz;

  logic [6:0] codes [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] exp_seg_of(input int v, input int lim, input bit tens);
    int d;
    d = tens ? (v / 10) : (v % 10);
    if (v > lim) return 7'h3F;
    return codes[d];
  endfunction

  // Model state: m = active edges since reset release; snapshot taken every FR edges
  int         m  = 0;
  int         sh = 0;
  int         sm = 0;
  int         ss = 0;
  logic [7:0] e_an  = 8'hFF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp  = 1'b1;
`ifdef HMS_SEG7_BLINK_EN
  bit         phase = 1'b0;
  int         fcnt  = 0;
`endif

  always @(posedge clk_100MHz) begin
    int slot, v, lim;
    if (reset) begin
      m = 0; sh = 0; sm = 0; ss = 0;
`ifdef HMS_SEG7_BLINK_EN
      phase = 1'b0; fcnt = 0;
`endif
    end else begin
      m++;
      slot = ((m - 1) / D) % 6;
      case (slot / 2)
        0:       begin v = ss; lim = 59; end
        1:       begin v = sm; lim = 59; end
        default: begin v = sh; lim = 23; end
      endcase
      e_seg = exp_seg_of(v, lim, (slot % 2) == 1);
      e_an  = 8'hFF ^ (8'd1 << slot);
      e_dp  = !(slot == 2 || slot == 4);
`ifdef HMS_SEG7_BLINK_EN
      if (blink_in && phase) begin
        e_an = 8'hFF;
        e_dp = 1'b1;
      end
`endif
      if (m % FR == 0) begin
        sh = int'(hour_in);
        sm = int'(min_in);
        ss = int'(sec_in);
`ifdef HMS_SEG7_BLINK_EN
        fcnt = (fcnt + 1) % BF;
        if (!blink_in) phase = 1'b0;
        else if (fcnt == 0) phase = !phase;
`endif
      end
    end
  end

  always @(negedge clk_100MHz) begin
    logic [7:0] w_an;
    logic [6:0] w_seg;
    logic       w_dp;
    if (reset) begin
      w_an = 8'hFF; w_seg = 7'h7F; w_dp = 1'b1;
    end else begin
      w_an = e_an; w_seg = e_seg; w_dp = e_dp;
    end
    checks++;
    if (an_out !== w_an || seg_out !== w_seg || dp_out !== w_dp) begin
      errors++;
      $display("FAIL model m=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               m, an_out, seg_out, dp_out, w_an, w_seg, w_dp);
    end
  end

  task automatic lit(input string name, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    checks++;
    if (an_out !== an || seg_out !== seg || dp_out !== dp) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               name, an_out, seg_out, dp_out, an, seg, dp);
    end
  endtask

  task automatic goto_edge(input int target);
    int n;
    n = 0;
    while (m != target && n < 1000) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (m != target) begin
      checks++;
      errors++;
      $display("FAIL goto_edge: got m=%0d, want %0d", m, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    lit("reset_hold", 8'hFF, 7'h7F, 1'b1);
    #2 reset = 1'b0;
    @(negedge clk_100MHz);
    lit("first_after_release", 8'hFE, 7'h40, 1'b1);

    hour_in = 5'd12; min_in = 6'd34; sec_in = 6'd56;
    goto_edge(25);  lit("f1_idx0",       8'hFE, 7'h02, 1'b1);
    goto_edge(28);  lit("f1_idx0_held",  8'hFE, 7'h02, 1'b1);
    goto_edge(29);  lit("f1_idx1",       8'hFD, 7'h12, 1'b1);
    goto_edge(33);  lit("f1_idx2",       8'hFB, 7'h19, 1'b0);
    goto_edge(37);  lit("f1_idx3",       8'hF7, 7'h30, 1'b1);
    goto_edge(41);  lit("f1_idx4",       8'hEF, 7'h24, 1'b0);
    goto_edge(45);  lit("f1_idx5",       8'hDF, 7'h79, 1'b1);

    goto_edge(62);
    hour_in = 5'd23; min_in = 6'd59; sec_in = 6'd59;
    goto_edge(65);  lit("midframe_old_idx4", 8'hEF, 7'h24, 1'b0);
    goto_edge(69);  lit("midframe_old_idx5", 8'hDF, 7'h79, 1'b1);
    goto_edge(73);  lit("new_frame_idx0",    8'hFE, 7'h10, 1'b1);
    goto_edge(93);  lit("new_frame_idx5",    8'hDF, 7'h24, 1'b1);

    goto_edge(94);
    hour_in = 5'd7; min_in = 6'd60; sec_in = 6'd5;
    goto_edge(97);  lit("oor_min_idx0", 8'hFE, 7'h12, 1'b1);
    goto_edge(101); lit("oor_min_idx1", 8'hFD, 7'h40, 1'b1);
    goto_edge(105); lit("oor_min_idx2", 8'hFB, 7'h3F, 1'b0);
    goto_edge(109); lit("oor_min_idx3", 8'hF7, 7'h3F, 1'b1);
    goto_edge(113); lit("oor_min_idx4", 8'hEF, 7'h78, 1'b0);
    goto_edge(117); lit("oor_min_idx5", 8'hDF, 7'h40, 1'b1);

    goto_edge(118);
    hour_in = 5'd24; min_in = 6'd0; sec_in = 6'd59;
    goto_edge(125); lit("hour24_sec_tens", 8'hFD, 7'h12, 1'b1);
    goto_edge(137); lit("hour24_idx4",     8'hEF, 7'h3F, 1'b0);
    goto_edge(141); lit("hour24_idx5",     8'hDF, 7'h3F, 1'b1);

    hour_in = 5'd12; min_in = 6'd34; sec_in = 6'd56;
    goto_edge(162);
    @(posedge clk_100MHz);
    #1 reset = 1'b1;
    #1 lit("reset_mid_scan", 8'hFF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk_100MHz);
    #2 reset = 1'b0;
    @(negedge clk_100MHz);
    lit("restart_idx0_snap0", 8'hFE, 7'h40, 1'b1);
    goto_edge(5);   lit("restart_idx1_snap0", 8'hFD, 7'h40, 1'b1);
    goto_edge(30);  lit("restart_f1_idx1",    8'hFD, 7'h12, 1'b1);

`ifdef HMS_SEG7_BLINK_EN
    blink_in = 1'b1;
    goto_edge(50);  lit("blink_off_frame",  8'hFF, 7'h02, 1'b1);
    goto_edge(100); lit("blink_on_frame",   8'hFE, 7'h02, 1'b1);
    goto_edge(150); lit("blink_off_again",  8'hFF, 7'h12, 1'b1);
    blink_in = 1'b0;
    goto_edge(170); lit("blink_released",   8'hFE, 7'h02, 1'b1);
    goto_edge(200);
`else
    goto_edge(60);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
